fma_pipe: RTL and testbench

//  Pipelined, parametrised IEEE-754 fused multiply-add: result = round(A*B + C), one rounding.

---
 rtl/fma_pipe.sv | 248 ++++++++++++++++++++++++
 tb/tb_fma_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fma_pipe.sv
// Three-stage pipelined fused multiply-add: result = round(a*b + c) with a
// single round-to-nearest-even step. Subnormal inputs and outputs are flushed
// to zero. One global enable stalls every stage while a result waits downstream.
//
// Handshake: an operand triple transfers on a rising edge where
// in_valid && in_ready; a result transfers where out_valid && out_ready.
// in_ready = !out_valid || out_ready, and while it is low no stage register
// changes, so a presented result and its flags stay stable until taken.
module fma_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [EXP_W+MAN_W:0] c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int P    = MAN_W + 1;          // significand width with hidden bit
    localparam int PW   = 2 * P;              // exact product width
    localparam int D    = 3 * P + 3;          // alignment field width
    localparam int SW   = D + 1;              // sum width incl. carry
    localparam int LZW  = $clog2(SW + 1);
    localparam int XW   = EXP_W + LZW + 2;    // signed internal exponent width
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int EMAX = 2 ** EXP_W - 1;
    // Exponent difference at which the addend sits unshifted at the top of the field
    localparam logic signed [XW-1:0] ALIGN0 = XW'(P + 3);
    localparam logic signed [XW-1:0] EMAX_X = XW'(EMAX);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---------------- S1: unpack, classify, multiply ----------------
    logic             sa, sb, sc;
    logic [EXP_W-1:0] ea, eb, ec;
    logic [MAN_W-1:0] fa, fb, fc;
    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;
    assign {sc, ec, fc} = c;

    logic a_zero, b_zero, c_zero, a_inf, b_inf, c_inf, a_nan, b_nan, c_nan;
    logic [P-1:0] sig_a, sig_b, sig_c;
    logic p_sign, p_inf, p_zero, any_nan, invalid, special;
    logic [W-1:0] spec_res;
    logic signed [XW-1:0] p_exp;
    logic [PW-1:0] prod;

    // Operand classification, exact product and the special-value outcome
    always_comb begin
        a_zero   = (ea == '0);
        b_zero   = (eb == '0);
        c_zero   = (ec == '0);
        a_inf    = (&ea) && (fa == '0);
        b_inf    = (&eb) && (fb == '0);
        c_inf    = (&ec) && (fc == '0);
        a_nan    = (&ea) && (fa != '0);
        b_nan    = (&eb) && (fb != '0);
        c_nan    = (&ec) && (fc != '0);
        sig_a    = a_zero ? '0 : {1'b1, fa};
        sig_b    = b_zero ? '0 : {1'b1, fb};
        sig_c    = c_zero ? '0 : {1'b1, fc};
        prod     = PW'(sig_a) * PW'(sig_b);
        p_exp    = XW'(ea) + XW'(eb) - XW'(BIAS);
        p_sign   = sa ^ sb;
        p_inf    = a_inf | b_inf;
        p_zero   = a_zero | b_zero;
        any_nan  = a_nan | b_nan | c_nan;
        invalid  = !any_nan && ((a_inf && b_zero) || (a_zero && b_inf) ||
                                (p_inf && c_inf && (p_sign != sc)));
        special  = any_nan || invalid || p_inf || c_inf;
        if (any_nan || invalid)
            spec_res = QNAN;
        else if (p_inf)
            spec_res = {p_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            spec_res = {sc, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end

    logic                 s1_valid, s1_psign, s1_pzero, s1_csign, s1_czero, s1_special;
    logic signed [XW-1:0] s1_pexp;
    logic [PW-1:0]        s1_prod;
    logic [EXP_W-1:0]     s1_cexp;
    logic [P-1:0]         s1_csig;
    logic [W-1:0]         s1_spec_res;
    logic                 s1_invalid;

    // Stage 1 register: product, addend and special outcome
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_psign    <= 1'b0;
            s1_pzero    <= 1'b0;
            s1_csign    <= 1'b0;
            s1_czero    <= 1'b0;
            s1_special  <= 1'b0;
            s1_pexp     <= '0;
            s1_prod     <= '0;
            s1_cexp     <= '0;
            s1_csig     <= '0;
            s1_spec_res <= '0;
            s1_invalid  <= 1'b0;
        end else if (en) begin
            s1_valid    <= in_valid;
            s1_psign    <= p_sign;
            s1_pzero    <= p_zero;
            s1_csign    <= sc;
            s1_czero    <= c_zero;
            s1_special  <= special;
            s1_pexp     <= p_exp;
            s1_prod     <= prod;
            s1_cexp     <= ec;
            s1_csig     <= sig_c;
            s1_spec_res <= spec_res;
            s1_invalid  <= invalid;
        end
    end

    // ---------------- S2: align and add ----------------
    logic signed [XW-1:0] c_exp_x, exp_diff, align_sh, hi_exp;
    logic                 c_top, c_sticky, eff_sub, sum_sign;
    logic [D-1:0]         p_field, c_full, c_field;
    logic [SW-1:0]        sum;

    // Addend placed relative to the product; far-away operand collapses to sticky
    always_comb begin
        c_exp_x  = XW'(s1_cexp);
        exp_diff = c_exp_x - s1_pexp;
        // A zero product must never push a nonzero addend out of the field
        c_top    = !s1_czero && (s1_pzero || (exp_diff > ALIGN0));
        align_sh = c_top ? '0 : ALIGN0 - exp_diff;
        hi_exp   = c_top ? c_exp_x : s1_pexp + ALIGN0;
        p_field  = c_top ? D'(s1_prod != '0) : D'({s1_prod, 1'b0});
        c_full   = {s1_csig, {(D-P){1'b0}}};
        c_field  = c_full >> align_sh;
        c_sticky = |(c_full & ~({D{1'b1}} << align_sh));
        c_field[0] = c_field[0] | c_sticky;
        eff_sub  = s1_psign ^ s1_csign;
        if (!eff_sub) begin
            sum      = {1'b0, p_field} + {1'b0, c_field};
            sum_sign = s1_psign;
        end else if (p_field >= c_field) begin
            sum      = {1'b0, p_field - c_field};
            sum_sign = s1_psign;
        end else begin
            sum      = {1'b0, c_field - p_field};
            sum_sign = s1_csign;
        end
    end

    logic                 s2_valid, s2_sign, s2_zsign, s2_special, s2_invalid;
    logic signed [XW-1:0] s2_exp;
    logic [SW-1:0]        s2_sum;
    logic [W-1:0]         s2_spec_res;

    // Stage 2 register: signed magnitude sum and exponent of its top bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            s2_sign     <= 1'b0;
            s2_zsign    <= 1'b0;
            s2_special  <= 1'b0;
            s2_invalid  <= 1'b0;
            s2_exp      <= '0;
            s2_sum      <= '0;
            s2_spec_res <= '0;
        end else if (en) begin
            s2_valid    <= s1_valid;
            s2_sign     <= sum_sign;
            s2_zsign    <= s1_pzero & s1_czero & s1_psign & s1_csign;
            s2_special  <= s1_special;
            s2_invalid  <= s1_invalid;
            s2_exp      <= hi_exp;
            s2_sum      <= sum;
            s2_spec_res <= s1_spec_res;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [LZW-1:0]       lz;
    logic [SW-1:0]        norm;
    logic [P-1:0]         mant;
    logic [P:0]           mant_rnd;
    logic [MAN_W-1:0]     frac_out;
    logic                 guard, round_bit, sticky, round_up, inexact;
    logic signed [XW-1:0] res_exp;
    logic [W-1:0]         res_next;
    logic [3:0]           flags_next;

    // Leading-zero normalise, RNE rounding and final result selection
    always_comb begin
        lz = LZW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (s2_sum[i]) lz = LZW'(SW - 1 - i);
        end
        norm      = s2_sum << lz;
        mant      = norm[SW-1 -: P];
        guard     = norm[SW-1-P];
        round_bit = norm[SW-2-P];
        sticky    = |norm[SW-3-P:0];
        round_up  = guard & (round_bit | sticky | mant[0]);
        inexact   = guard | round_bit | sticky;
        mant_rnd  = {1'b0, mant} + {{P{1'b0}}, round_up};
        // A rounding carry leaves 10..0, so the fraction field is zero either way
        frac_out  = mant_rnd[P] ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
        res_exp   = s2_exp + XW'(1) - XW'(lz) + XW'(mant_rnd[P]);
        res_next   = '0;
        flags_next = '0;
        if (s2_special) begin
            res_next   = s2_spec_res;
            flags_next = {s2_invalid, 3'b000};
        end else if (s2_sum == '0) begin
            res_next   = {s2_zsign, {(W-1){1'b0}}};
        end else if (res_exp >= EMAX_X) begin
            res_next   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_next = 4'b0101;
        end else if (res_exp[XW-1] || (res_exp == '0)) begin
            res_next   = {s2_sign, {(W-1){1'b0}}};
            flags_next = 4'b0011;
        end else begin
            res_next   = {s2_sign, res_exp[EXP_W-1:0], frac_out};
            flags_next = {3'b000, inexact};
        end
    end

    // Output register: packed result, flags and out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (en) begin
            out_valid <= s2_valid;
            result    <= res_next;
            flags     <= flags_next;
        end
    end

endmodule

// File: tb/tb_fma_pipe.sv
// Directed bench for fma_pipe (binary32): vector table, latency, stall and
// mid-flight reset sequences, all against hand-computed expectations.
module tb_fma_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, c, result;
    logic [3:0]  flags;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];
    logic [35:0] exp_q[$];

    fma_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    // clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    task automatic apply(input int idx);
        a = vecs[idx].a;
        b = vecs[idx].b;
        c = vecs[idx].c;
    endtask

    // Send one op into an idle pipe, check latency, result and flags.
    // Entered and left #1 after a rising edge.
    task automatic run_vec(input int idx, input string tag);
        int lat;
        bit seen;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        apply(idx);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1 lat++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no out_valid within 20 cycles", tag);
        end else begin
            check({tag, " latency"}, lat, 3);
            check({tag, " result"}, result, vecs[idx].res);
            check({tag, " flags"}, {28'd0, flags}, {28'd0, vecs[idx].flg});
        end
        @(posedge clk);
        #1;
    endtask

    // Four back-to-back ops; the first result is held off for two cycles
    task automatic stall_seq();
        int ops[4];
        int sent, got, cyc, stall_cnt;
        bit stalled_once, in_xfer, out_xfer, extra;
        logic [31:0] held_r;
        logic [3:0]  held_f;
        logic [35:0] want;
        ops = '{0, 1, 19, 20};
        sent = 0; got = 0; cyc = 0; stall_cnt = 0; stalled_once = 1'b0;
        held_r = '0; held_f = '0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        apply(ops[0]);
        while (got < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (out_valid && !stalled_once) begin
                stalled_once = 1'b1;
                stall_cnt    = 2;
                held_r       = result;
                held_f       = flags;
            end
            out_ready = (stall_cnt == 0);
            #1;
            if (stall_cnt > 0) begin
                check("t5 in_ready during stall", {31'd0, in_ready}, 32'd0);
                check("t5 result held", result, held_r);
                check("t5 flags held", {28'd0, flags}, {28'd0, held_f});
                stall_cnt--;
            end
            out_xfer = out_valid && out_ready;
            in_xfer  = in_valid && in_ready;
            if (out_xfer) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL t5 extra result: got %h, expected none", result);
                end else begin
                    want = exp_q.pop_front();
                    check($sformatf("t5 out%0d result", got), result, want[35:4]);
                    check($sformatf("t5 out%0d flags", got), {28'd0, flags}, {28'd0, want[3:0]});
                end
                got++;
            end
            if (in_xfer) exp_q.push_back({vecs[ops[sent]].res, vecs[ops[sent]].flg});
            @(posedge clk);
            #1;
            if (in_xfer) begin
                sent++;
                if (sent < 4) apply(ops[sent]);
                else in_valid = 1'b0;
            end
        end
        check("t5 results received", got, 4);
        check("t5 stall happened", {31'd0, stalled_once}, 32'd1);
        check("t5 queue drained", exp_q.size(), 0);
        out_ready = 1'b1;
        extra = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) extra = 1'b1;
        end
        check("t5 no duplicate output", {31'd0, extra}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        //              a             b             c             result        flags
        vecs[0]  = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40400000, 4'h0}; // 1*2+1
        vecs[1]  = '{32'h3F800001, 32'h3F800001, 32'hBF800002, 32'h28800000, 4'h0}; // single rounding
        vecs[2]  = '{32'h7F800000, 32'h00000000, 32'h3F800000, 32'h7FC00000, 4'h8}; // inf*0
        vecs[3]  = '{32'h7F800000, 32'h3F800000, 32'hFF800000, 32'h7FC00000, 4'h8}; // inf-inf
        vecs[4]  = '{32'h7F7FFFFF, 32'h40000000, 32'h00000000, 32'h7F800000, 4'h5}; // overflow
        vecs[5]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 32'h00000000, 4'h3}; // underflow
        vecs[6]  = '{32'h7F800001, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'h0}; // NaN wins
        vecs[7]  = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 32'hFF800000, 4'h0}; // -inf + -inf
        vecs[8]  = '{32'h3F800000, 32'h3F800000, 32'hFF800000, 32'hFF800000, 4'h0}; // c = -inf
        vecs[9]  = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h00000000, 4'h0}; // exact cancel
        vecs[10] = '{32'h80000000, 32'h3F800000, 32'h80000000, 32'h80000000, 4'h0}; // -0 + -0
        vecs[11] = '{32'h80000000, 32'h3F800000, 32'h00000000, 32'h00000000, 4'h0}; // -0 + +0
        vecs[12] = '{32'h00000001, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'h0}; // denormal flushed
        vecs[13] = '{32'h3F800000, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'h1}; // tie, even down
        vecs[14] = '{32'h3F800001, 32'h3F800000, 32'h33800000, 32'h3F800002, 4'h1}; // tie, odd up
        vecs[15] = '{32'h3F800000, 32'h3F800000, 32'h33C00000, 32'h3F800001, 4'h1}; // above half
        vecs[16] = '{32'h3F7FFFFF, 32'h3F800000, 32'h33000000, 32'h3F800000, 4'h1}; // round carry-out
        vecs[17] = '{32'h3F800000, 32'h3F800000, 32'hA1800000, 32'h3F800000, 4'h1}; // 1 - 2^-60
        vecs[18] = '{32'h3F800000, 32'h3F800000, 32'h53800000, 32'h53800000, 4'h1}; // 2^40 + 1
        vecs[19] = '{32'h3F800000, 32'h3F800000, 32'hC0000000, 32'hBF800000, 4'h0}; // 1 - 2
        vecs[20] = '{32'h40400000, 32'h40A00000, 32'h00000000, 32'h41700000, 4'h0}; // 3*5
        vecs[21] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 4'h5}; // max+max

        // reset
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", {28'd0, flags}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);

        // table of single ops
        for (int i = 0; i < NV; i++) run_vec(i, $sformatf("vec%0d", i));

        // back-to-back with downstream stall
        stall_seq();

        // reset with three ops in flight
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            apply(k);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("t6 pipe full before reset", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6 out_valid in reset", {31'd0, out_valid}, 32'd0);
        check("t6 result in reset", result, 32'd0);
        check("t6 flags in reset", {28'd0, flags}, 32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("t6 no stale output", {31'd0, seen}, 32'd0);
        @(posedge clk);
        #1;
        run_vec(20, "t6 after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
